serial_receiver: RTL and testbench

Serial-to-parallel receive stage, sitting directly downstream of the N-bit serial transmitter.
- Collects N-bit chunks MSB-first into 32-bit words.
- Pushes each complete word into a small first-word-fall-through output FIFO drained by the consumer.
- Uses the transmitter's frame-done strobe to detect truncated frames.
- Flags overflow of the output FIFO.

---
 rtl/serial_receiver.sv | 195 +++++++++++++++++++
 tb/tb_serial_receiver.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_receiver.sv
// ----------------------------------------------------------------------------
// serial_receiver
//
// Receive stage for the N-bit serial transmitter. Incoming chunks are
// assembled MSB-first into 32-bit words. Each completed word is pushed into
// a small first-word-fall-through FIFO that the consumer drains. The
// transmitter's frame-done strobe is used to detect truncated frames.
//
// Parameters
//   N      bits per serial chunk (1, 2, 4, 8, 16 or 32)
//   DEPTH  output FIFO depth in words (power of two, >= 2)
//
// Ports
//   Clk       in   system clock, all state changes on posedge
//   Reset     in   asynchronous active-high reset
//   Din       in   serial chunk; the first chunk of a word is its MSBs
//   DinValid  in   Din is sampled on this edge
//   FrameEnd  in   one-cycle end-of-frame strobe from the transmitter
//   RdEn      in   pop the FIFO head (ignored while Empty)
//   DataOut   out  FIFO head word, meaningful while Empty=0
//   Empty     out  FIFO holds no words
//   Full      out  FIFO holds DEPTH words
//   Count     out  number of words in the FIFO
//   RxBusy    out  a partial word is being assembled
//   FrameErr  out  one-cycle pulse: frame ended with a partial word
//   Overrun   out  sticky: a completed word was dropped on a full FIFO
// ----------------------------------------------------------------------------
module serial_receiver #(
    parameter int N     = 1,
    parameter int DEPTH = 4
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [N-1:0]             Din,
    input  logic                     DinValid,
    input  logic                     FrameEnd,
    input  logic                     RdEn,
    output logic [31:0]              DataOut,
    output logic                     Empty,
    output logic                     Full,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     RxBusy,
    output logic                     FrameErr,
    output logic                     Overrun
);

    localparam int CHUNKS = 32 / N;
    localparam int CW     = $clog2(CHUNKS) + 1;
    localparam int PW     = $clog2(DEPTH);
    localparam int CNTW   = PW + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]      state_q,     state_d;
    logic [CW-1:0]   cnt_q,       cnt_d;
    logic [31:0]     shift_q,     shift_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q,   overrun_d;
    logic [PW-1:0]   wr_ptr_q,    wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q,    rd_ptr_d;
    logic [CNTW-1:0] count_q,     count_d;
    logic [31:0]     mem_q [DEPTH];
    logic [31:0]     mem_d [DEPTH];

    logic [31:0]     word_next;
    logic            word_done;
    logic            pop;
    logic            fifo_push;
    logic            fifo_full;

    // ------------------------------------------------------------------
    // Assembly FSM
    // ------------------------------------------------------------------
    always_comb begin
        // Concatenate then truncate so the same expression also covers
        // N=32, where the incoming chunk is the whole word.
        word_next   = 32'({shift_q, Din});

        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        word_done   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // FrameEnd with no word in progress has nothing to flag.
                if (DinValid) begin
                    if (CHUNKS == 1) begin
                        word_done = 1'b1;
                    end else begin
                        shift_d = word_next;
                        cnt_d   = CW'(1);
                        state_d = ST_RECV;
                    end
                end
            end
            ST_RECV: begin
                // A completing chunk wins over FrameEnd: the word is whole.
                if (DinValid && (cnt_q == CW'(CHUNKS - 1))) begin
                    word_done = 1'b1;
                    shift_d   = word_next;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else if (FrameEnd) begin
                    // Truncated frame: drop the partial word and any chunk
                    // arriving on this same edge.
                    frame_err_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                end else if (DinValid) begin
                    shift_d = word_next;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    always_comb begin
        fifo_full = (count_q == CNTW'(DEPTH));
        pop       = RdEn && (count_q != '0);
        // A pop on the same edge frees the slot, so a full FIFO still
        // accepts the word.
        fifo_push = word_done && (!fifo_full || pop);
        overrun_d = overrun_q | (word_done && fifo_full && !pop);

        count_d = count_q;
        case ({fifo_push, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase

        wr_ptr_d = fifo_push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = pop       ? (rd_ptr_q + PW'(1)) : rd_ptr_q;

        mem_d = mem_q;
        if (fifo_push) begin
            mem_d[wr_ptr_q] = word_next;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            // Storage is cleared so DataOut reads zero straight out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_q       <= mem_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign DataOut  = mem_q[rd_ptr_q];
    assign Empty    = (count_q == '0);
    assign Full     = fifo_full;
    assign Count    = count_q;
    assign RxBusy   = (state_q == ST_RECV);
    assign FrameErr = frame_err_q;
    assign Overrun  = overrun_q;

endmodule

// File: tb/tb_serial_receiver.sv
// ----------------------------------------------------------------------------
// tb_serial_receiver
//
// Two receivers share clock and reset: u_n1 (N=1) and u_n8 (N=8), both with
// DEPTH=4. A behavioural model tracks chunk counts, word values and a word
// queue per receiver and is checked on every clock; directed scenarios add
// hand-computed literal checks.
// ----------------------------------------------------------------------------
module tb_serial_receiver;

    logic        clk;
    logic        rst;

    logic        din1, dv1, fe1, rd1;
    logic [31:0] do1;
    logic        em1, fu1, bz1, fer1, ov1;
    logic [2:0]  cn1;

    logic [7:0]  din8;
    logic        dv8, fe8, rd8;
    logic [31:0] do8;
    logic        em8, fu8, bz8, fer8, ov8;
    logic [2:0]  cn8;

    int nvec  = 0;
    int nfail = 0;

    serial_receiver #(.N(1), .DEPTH(4)) u_n1 (
        .Clk(clk), .Reset(rst), .Din(din1), .DinValid(dv1), .FrameEnd(fe1),
        .RdEn(rd1), .DataOut(do1), .Empty(em1), .Full(fu1), .Count(cn1),
        .RxBusy(bz1), .FrameErr(fer1), .Overrun(ov1)
    );

    serial_receiver #(.N(8), .DEPTH(4)) u_n8 (
        .Clk(clk), .Reset(rst), .Din(din8), .DinValid(dv8), .FrameEnd(fe8),
        .RdEn(rd8), .DataOut(do8), .Empty(em8), .Full(fu8), .Count(cn8),
        .RxBusy(bz8), .FrameErr(fer8), .Overrun(ov8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Comparison helpers
    // ------------------------------------------------------------------
    task automatic cmpw(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmpb(input string nm, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: index 0 is the N=1 receiver, index 1 the N=8 one
    // ------------------------------------------------------------------
    int          m_pc   [2];
    logic [31:0] m_part [2];
    logic        m_ferr [2];
    logic        m_ovr  [2];
    logic [31:0] mq0 [$];
    logic [31:0] mq1 [$];

    function automatic int msize(input int k);
        return (k == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic logic [31:0] mhead(input int k);
        return (k == 0) ? mq0[0] : mq1[0];
    endfunction

    // Append one nb-bit chunk below the bits collected so far.
    function automatic logic [31:0] shin(input logic [31:0] p, input logic [31:0] d, input int nb);
        longint sc, dm, t;
        sc = longint'(1) << nb;
        dm = longint'(d) % sc;
        t  = longint'(p) * sc + dm;
        return t[31:0];
    endfunction

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k]   = 0;
            m_part[k] = '0;
            m_ferr[k] = 1'b0;
            m_ovr[k]  = 1'b0;
        end
        mq0.delete();
        mq1.delete();
    endtask

    task automatic mstep(input int k, input int nb, input logic [31:0] d,
                         input logic dv, input logic fe, input logic rd);
        int          c;
        logic        pop, done;
        logic [31:0] w, tmp;
        c         = 32 / nb;
        pop       = rd && (msize(k) > 0);
        done      = 1'b0;
        w         = '0;
        m_ferr[k] = 1'b0;
        if (dv && (m_pc[k] + 1 == c)) begin
            done      = 1'b1;
            w         = shin(m_part[k], d, nb);
            m_pc[k]   = 0;
            m_part[k] = '0;
        end else if ((m_pc[k] > 0) && fe) begin
            m_ferr[k] = 1'b1;
            m_pc[k]   = 0;
            m_part[k] = '0;
        end else if (dv) begin
            m_part[k] = shin(m_part[k], d, nb);
            m_pc[k]   = m_pc[k] + 1;
        end
        if (pop) begin
            if (k == 0) tmp = mq0.pop_front();
            else        tmp = mq1.pop_front();
        end
        if (done) begin
            if (msize(k) < 4) begin
                if (k == 0) mq0.push_back(w);
                else        mq1.push_back(w);
            end else begin
                m_ovr[k] = 1'b1;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mreset();
        end else begin
            mstep(0, 1, {31'b0, din1}, dv1, fe1, rd1);
            mstep(1, 8, {24'b0, din8}, dv8, fe8, rd8);
        end
    end

    task automatic chk_dut(input int k, input logic [31:0] dout, input logic em,
                           input logic fu, input logic [2:0] cn, input logic bz,
                           input logic fer, input logic ov);
        string p;
        p = $sformatf("model_dut%0d", k);
        cmpb({p, "_empty"},    em,  msize(k) == 0);
        cmpb({p, "_full"},     fu,  msize(k) == 4);
        cmpw({p, "_count"},    32'(cn), 32'(msize(k)));
        cmpb({p, "_rxbusy"},   bz,  m_pc[k] > 0);
        cmpb({p, "_frameerr"}, fer, m_ferr[k]);
        cmpb({p, "_overrun"},  ov,  m_ovr[k]);
        if (msize(k) > 0) cmpw({p, "_dataout"}, dout, mhead(k));
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            chk_dut(0, do1, em1, fu1, cn1, bz1, fer1, ov1);
            chk_dut(1, do8, em8, fu8, cn8, bz8, fer8, ov8);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bit1(input logic b);
        din1 = b; dv1 = 1'b1;
        step();
        dv1 = 1'b0; din1 = 1'b0;
    endtask

    task automatic chunk8(input logic [7:0] c, input logic f, input logic r);
        din8 = c; dv8 = 1'b1; fe8 = f; rd8 = r;
        step();
        dv8 = 1'b0; fe8 = 1'b0; rd8 = 1'b0; din8 = '0;
    endtask

    task automatic send8(input logic [31:0] w, input logic f, input logic r);
        for (int i = 0; i < 4; i++) begin
            chunk8(w[31-8*i -: 8], (i == 3) && f, (i == 3) && r);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pop8();
        rd8 = 1'b1;
        step();
        rd8 = 1'b0;
    endtask

    initial begin
        logic [31:0] w;

        rst = 1'b0;
        din1 = 1'b0; dv1 = 1'b0; fe1 = 1'b0; rd1 = 1'b0;
        din8 = '0;   dv8 = 1'b0; fe8 = 1'b0; rd8 = 1'b0;
        #1 rst = 1'b1;
        #2;
        cmpb("rst_empty1", em1, 1'b1);
        cmpb("rst_full1", fu1, 1'b0);
        cmpw("rst_count1", 32'(cn1), 32'd0);
        cmpb("rst_busy1", bz1, 1'b0);
        cmpb("rst_ferr1", fer1, 1'b0);
        cmpb("rst_ovr1", ov1, 1'b0);
        cmpw("rst_dout1", do1, 32'h0);
        cmpb("rst_empty8", em8, 1'b1);
        cmpw("rst_dout8", do8, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // 32 single-bit chunks of 0xA5A50F0F
        w = 32'hA5A50F0F;
        for (int i = 31; i >= 0; i--) begin
            bit1(w[i]);
            if (i > 0) cmpb("t1_busy_mid", bz1, 1'b1);
        end
        cmpb("t1_busy_end", bz1, 1'b0);
        cmpb("t1_empty", em1, 1'b0);
        cmpw("t1_count", 32'(cn1), 32'd1);
        cmpw("t1_dout", do1, 32'hA5A50F0F);
        rd1 = 1'b1; step(); rd1 = 1'b0;
        cmpb("t1_empty_after_rd", em1, 1'b1);
        cmpw("t1_count_after_rd", 32'(cn1), 32'd0);
        rd1 = 1'b1; step(); rd1 = 1'b0;
        cmpw("t1_no_underflow", 32'(cn1), 32'd0);

        // Gapped byte chunks, FrameEnd on the final chunk
        chunk8(8'hDE, 1'b0, 1'b0);
        chunk8(8'hAD, 1'b0, 1'b0);
        idle(3);
        cmpb("t2_busy_gap", bz8, 1'b1);
        chunk8(8'hBE, 1'b0, 1'b0);
        idle(1);
        chunk8(8'hEF, 1'b1, 1'b0);
        cmpb("t2_no_ferr", fer8, 1'b0);
        cmpw("t2_dout", do8, 32'hDEADBEEF);
        cmpw("t2_count", 32'(cn8), 32'd1);
        pop8();

        // Truncated frame
        chunk8(8'h11, 1'b0, 1'b0);
        chunk8(8'h22, 1'b0, 1'b0);
        fe8 = 1'b1; step(); fe8 = 1'b0;
        cmpb("t3_ferr_pulse", fer8, 1'b1);
        cmpb("t3_busy_clr", bz8, 1'b0);
        cmpw("t3_count", 32'(cn8), 32'd0);
        step();
        cmpb("t3_ferr_one_cycle", fer8, 1'b0);
        send8(32'h01020304, 1'b0, 1'b0);
        cmpw("t3_dout", do8, 32'h01020304);
        pop8();

        // Full FIFO with push and pop on the same edge
        for (int v = 1; v <= 4; v++) send8(32'(v), 1'b0, 1'b0);
        cmpb("t5_full", fu8, 1'b1);
        send8(32'd6, 1'b0, 1'b1);
        cmpw("t5_count", 32'(cn8), 32'd4);
        cmpb("t5_no_ovr", ov8, 1'b0);
        cmpw("t5_rd0", do8, 32'd2); pop8();
        cmpw("t5_rd1", do8, 32'd3); pop8();
        cmpw("t5_rd2", do8, 32'd4); pop8();
        cmpw("t5_rd3", do8, 32'd6); pop8();
        cmpb("t5_empty", em8, 1'b1);

        // Overflow
        for (int v = 1; v <= 4; v++) send8(32'(v), 1'b0, 1'b0);
        cmpw("t4_count4", 32'(cn8), 32'd4);
        cmpb("t4_ovr_before", ov8, 1'b0);
        send8(32'd5, 1'b0, 1'b0);
        cmpw("t4_count_after5", 32'(cn8), 32'd4);
        cmpb("t4_full", fu8, 1'b1);
        cmpb("t4_ovr", ov8, 1'b1);
        for (int v = 1; v <= 4; v++) begin
            cmpw($sformatf("t4_rd%0d", v), do8, 32'(v));
            pop8();
        end
        cmpb("t4_empty", em8, 1'b1);
        cmpb("t4_ovr_sticky", ov8, 1'b1);

        // Asynchronous reset mid-word and with a word queued
        send8(32'hCAFEF00D, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) bit1(1'b1);
        #3 rst = 1'b1;
        #1;
        cmpb("t6_busy1", bz1, 1'b0);
        cmpb("t6_empty1", em1, 1'b1);
        cmpw("t6_dout1", do1, 32'h0);
        cmpb("t6_empty8", em8, 1'b1);
        cmpw("t6_count8", 32'(cn8), 32'd0);
        cmpb("t6_ovr8", ov8, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        w = 32'h80000001;
        for (int i = 31; i >= 0; i--) bit1(w[i]);
        cmpw("t6_dout", do1, 32'h80000001);
        cmpw("t6_count", 32'(cn1), 32'd1);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
